// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU pushes bytes into a small FIFO at ADDR_DATA,
// polls status at ADDR_STATUS; an 8N1 serializer drains the FIFO LSB first.
module uart_tx_mmio #(
  parameter logic [15:0] ADDR_DATA    = 16'hFFF0,
  parameter logic [15:0] ADDR_STATUS  = 16'hFFF1,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        wire_clock_50Mhz,
  input  logic        wire_reset,
  input  logic [15:0] bus_RAM_ADDRESS,
  input  logic [15:0] bus_RAM_DATA_IN,
  input  logic        wire_RW,
  input  logic        wire_bus_strobe,
  output logic        wire_io_sel,
  output logic [15:0] bus_IO_DATA_OUT,
  output logic        wire_uart_tx,
  output logic        wire_tx_busy
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic sel_data, sel_status, wr_data, rd_data, rd_status;
  logic full, empty, push, drop, pop, baud_done;
  logic unused_data_hi;

  assign sel_data    = (bus_RAM_ADDRESS == ADDR_DATA);
  assign sel_status  = (bus_RAM_ADDRESS == ADDR_STATUS);
  assign wire_io_sel = sel_data | sel_status;

  assign wr_data   = wire_bus_strobe &  wire_RW & sel_data;
  assign rd_data   = wire_bus_strobe & ~wire_RW & sel_data;
  assign rd_status = wire_bus_strobe & ~wire_RW & sel_status;

  assign full      = (count_q == FIFO_FULL);
  assign empty     = (count_q == '0);
  assign push      = wr_data & ~full;
  assign drop      = wr_data & full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign baud_done = (baud_q == BAUD_LAST);

  assign unused_data_hi = ^bus_RAM_DATA_IN[15:8];

  assign bus_IO_DATA_OUT = rdata_q;
  assign wire_uart_tx    = tx_q;
  assign wire_tx_busy    = busy_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rdata_d    = rdata_q;
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a status read must leave the flag set.
    if (rd_status) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;

    if (rd_status)
      rdata_d = {5'b0, 7'(count_q), overflow_q, busy_q, full, empty};
    else if (rd_data)
      rdata_d = 16'h0000;

    // tx/busy are registered, so they are computed from the state being entered.
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_d];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wire_clock_50Mhz) begin
    if (wire_reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: FIFO storage has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge wire_clock_50Mhz) begin
    if (push && !wire_reset) mem_q[wr_ptr_q] <= bus_RAM_DATA_IN[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4 and an 8-deep FIFO.
module tb_uart_tx_mmio;

  localparam logic [15:0] A_DATA   = 16'hFFF0;
  localparam logic [15:0] A_STATUS = 16'hFFF1;
  localparam int          CPB      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic        rw = 1'b0;
  logic        strobe = 1'b0;
  logic        io_sel;
  logic [15:0] dout;
  logic        tx;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  uart_tx_mmio #(
    .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STATUS), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)
  ) dut (
    .wire_clock_50Mhz(clk),
    .wire_reset(rst),
    .bus_RAM_ADDRESS(addr),
    .bus_RAM_DATA_IN(din),
    .wire_RW(rw),
    .wire_bus_strobe(strobe),
    .wire_io_sel(io_sel),
    .bus_IO_DATA_OUT(dout),
    .wire_uart_tx(tx),
    .wire_tx_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_access(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(negedge clk);
    addr = a; din = d; rw = w; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Samples one frame mid-bit; returns at the last stop-bit cycle.
  task automatic rx_frame(output logic [7:0] b, output int t_start);
    int waited = 0;
    b = '0;
    t_start = -1;
    while (tx !== 1'b0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check("rx_start_seen", 0, 1);
      return;
    end
    t_start = cyc;
    for (int off = 1; off <= 39; off++) begin
      @(negedge clk);
      if (off == 2) check("rx_start_bit", tx, 0);
      if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) b[(off - 6) / 4] = tx;
      if (off == 38) check("rx_stop_bit", tx, 1);
    end
  endtask

  initial begin
    logic [9:0]  pat;
    logic [7:0]  b0, b1, b2;
    int          t0, t1, t2;
    logic        saw_low;

    // Reset state, address decode, idle status and data-register read
    do_reset();
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_dout", dout, 16'h0000);
    addr = A_DATA;   #1 check("io_sel_data", io_sel, 1);
    addr = A_STATUS; #1 check("io_sel_status", io_sel, 1);
    addr = '0;
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("status_idle", dout, 16'h0001);

    // Foreign address: no decode, no push, output held
    @(negedge clk);
    addr = 16'h1234; din = 16'h00AA; rw = 1'b1; strobe = 1'b1;
    #1 check("io_sel_foreign", io_sel, 0);
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; addr = '0;
    check("foreign_wr_dout", dout, 16'h0001);
    bus_access(16'h1234, 16'h0, 1'b0);
    check("foreign_rd_dout", dout, 16'h0001);
    check("foreign_no_tx", tx, 1);
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("foreign_status", dout, 16'h0001);
    bus_access(A_DATA, 16'h0, 1'b0);
    check("data_read", dout, 16'h0000);

    // Single 0xA5 frame: bit-by-bit waveform and busy window
    pat = {1'b1, 8'hA5, 1'b0};
    bus_access(A_DATA, 16'h00A5, 1'b1);
    check("a5_pre_fall_tx", tx, 1);
    check("a5_pre_fall_busy", busy, 0);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      check($sformatf("a5_tx_c%0d", c), tx, pat[c / CPB]);
      check($sformatf("a5_busy_c%0d", c), busy, 1);
    end
    @(negedge clk);
    check("a5_end_tx", tx, 1);
    check("a5_end_busy", busy, 0);

    // Three back-to-back frames: spacing and order
    fork
      begin
        bus_access(A_DATA, 16'h0011, 1'b1);
        bus_access(A_DATA, 16'hFF22, 1'b1);
        bus_access(A_DATA, 16'h0033, 1'b1);
      end
      begin
        rx_frame(b0, t0);
        rx_frame(b1, t1);
        rx_frame(b2, t2);
      end
    join
    check("b2b_byte0", b0, 8'h11);
    check("b2b_byte1", b1, 8'h22);
    check("b2b_byte2", b2, 8'h33);
    check("b2b_gap01", t1 - t0, 10 * CPB + 1);
    check("b2b_gap12", t2 - t1, 10 * CPB + 1);
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("b2b_status", dout, 16'h0001);

    // Overflow: one byte in flight, eight queued, one dropped
    do_reset();
    @(negedge clk);
    check("ovf_reset_dout", dout, 16'h0000);
    for (int i = 0; i < 10; i++) bus_access(A_DATA, 16'(8'h10 + i), 1'b1);
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("ovf_status1", dout, 16'h008E);
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("ovf_status2", dout, 16'h0086);

    // Reset in DATA bit 3 with two bytes queued; strobe during reset ignored
    do_reset();
    bus_access(A_DATA, 16'h00A5, 1'b1);
    bus_access(A_DATA, 16'h005A, 1'b1);
    bus_access(A_DATA, 16'h00C3, 1'b1);
    repeat (14) @(negedge clk);
    check("mid_bit3_tx", tx, 0);
    check("mid_bit3_busy", busy, 1);
    rst = 1'b1;
    addr = A_DATA; din = 16'h0077; rw = 1'b1; strobe = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0; strobe = 1'b0; rw = 1'b0; addr = '0;
    bus_access(A_STATUS, 16'h0, 1'b0);
    check("abort_status", dout, 16'h0001);
    saw_low = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("abort_no_frames", saw_low, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
- REQ-001 SHALL have parameter ADDR_DATA, default 16'hFFF0: CPU write address of the TX data register.
- REQ-002 SHALL have parameter ADDR_STATUS, default 16'hFFF1: CPU read address of the status register.
- REQ-003 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (115200 baud at 50 MHz), legal range 2..65535.
- REQ-004 SHALL have parameter FIFO_DEPTH, default 8: TX byte FIFO depth, power of two, range 2..64.
- REQ-005 wire_clock_50Mhz  in  1  single clock; all state changes on its rising edge.
- REQ-006 wire_reset  in  1  synchronous, active-high reset.
- REQ-007 bus_RAM_ADDRESS  in  16  CPU bus address.
- REQ-008 bus_RAM_DATA_IN  in  16  CPU write data; bits [7:0] are used.
- REQ-009 wire_RW  in  1  bus direction: 1 = CPU write, 0 = CPU read.
- REQ-010 wire_bus_strobe  in  1  one-cycle pulse per CPU bus access; address, data and RW are valid while it is high.
- REQ-011 wire_io_sel  out  1  combinational; high when bus_RAM_ADDRESS equals ADDR_DATA or ADDR_STATUS.
- REQ-012 bus_IO_DATA_OUT  out  16  registered read data for the CPU.
- REQ-013 wire_uart_tx  out  1  serial output, idle high.
- REQ-014 wire_tx_busy  out  1  high while a frame is being shifted out.

Function
- REQ-015 A write SHALL be strobe=1, RW=1 and address=ADDR_DATA; it pushes bus_RAM_DATA_IN[7:0] into the FIFO.
- REQ-016 A push SHALL be dropped when the FIFO is full (pre-edge count = FIFO_DEPTH), even if a pop occurs on the same edge; a drop sets the sticky overflow flag.
- REQ-017 A status read SHALL be strobe=1, RW=0 and address=ADDR_STATUS.
- REQ-018 On a status read, bus_IO_DATA_OUT SHALL update on the next edge to {count[6:0] in bits [10:4], overflow in bit 3, tx_busy in bit 2, full in bit 1, empty in bit 0}, with all other bits 0.
- REQ-019 A status read SHALL clear overflow on the same edge; if an overflow occurs on that same edge, overflow SHALL remain set.
- REQ-020 A read of ADDR_DATA SHALL load 16'h0000 into bus_IO_DATA_OUT.
- REQ-021 bus_IO_DATA_OUT SHALL hold its value when no read occurs.
- REQ-022 Accesses to any other address SHALL be ignored.
- REQ-023 FIFO SHALL use wrapping read/write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits. Pushes and pops on the same edge leave count unchanged.
- REQ-024 TX FSM states: IDLE, START, DATA, STOP.
- REQ-025 IDLE: tx=1, busy=0. If the FIFO is non-empty (pre-edge), pop the head into the shift register, clear the baud counter and go to START. This gives 1 cycle of latency from push to the falling start edge when the FIFO is empty and idle.
- REQ-026 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- REQ-027 DATA: tx=shift[bit index], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
- REQ-028 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. Back-to-back frames therefore have no extra idle cycle beyond the one IDLE cycle.
- REQ-029 busy SHALL be high in START, DATA and STOP.
- REQ-030 Total frame length SHALL be exactly 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle, between consecutive start edges.
- REQ-031 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary.

Reset
- REQ-032 While wire_reset=1 at an edge, the block SHALL set: FSM=IDLE, wire_uart_tx=1, wire_tx_busy=0, FIFO pointers and count=0, overflow=0, bus_IO_DATA_OUT=16'h0000, baud counter and bit index=0.
- REQ-033 Reset during a frame SHALL abort it immediately: tx is high from the next edge, and any queued bytes are discarded.
- REQ-034 Bus strobes while reset=1 SHALL be ignored.

Verification
- REQ-035 Reset, then write 8'hA5 to ADDR_DATA, with CLKS_PER_BIT=4 -> tx falls 1 cycle after the push and shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit held 4 cycles. busy is high for 40 cycles.
- REQ-036 Write 9 bytes with no intervening pop (FSM held busy, FIFO_DEPTH=8) -> the 9th byte is dropped. A status read returns bit3=1 and bit1=1; a second status read returns bit3=0.
- REQ-037 Write 3 bytes back-to-back -> three frames with start edges exactly 10*CLKS_PER_BIT+1 cycles apart, byte order preserved.
- REQ-038 Status read while idle and empty -> bus_IO_DATA_OUT=16'h0001 on the next edge; a read of ADDR_DATA -> 16'h0000.
- REQ-039 Assert reset in the middle of DATA bit 3 with 2 bytes queued -> tx=1, busy=0 and status 16'h0001 after release; no further frames are sent.
- REQ-040 Strobe with address 16'h1234 and RW=1 -> wire_io_sel=0, and FIFO and output are unchanged.
